// File: rtl/doodle_pkg.sv
// Shared types and constants for the doodle jump controller.
// DOODLE_WRAP_EN selects horizontal wrap-around instead of edge clamping.
package doodle_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE,
        S_SCAN,
        S_COMMIT,
        S_OVER
    } ctrl_state_t;

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    localparam int W           = 320;
    localparam int H           = 240;
    localparam int SIZE        = 4;
    localparam int X_STEP      = 3;
    localparam int GRAV        = 1;
    localparam int JUMP_V      = 6;
    localparam int VMAX        = 8;
    localparam int N_PLAT      = 8;
    localparam int PLAT_W      = 16;
    localparam int SCROLL_LINE = 80;

    localparam int IDX_W = $clog2(N_PLAT);
    localparam int CNT_W = $clog2(N_PLAT + 1);

endpackage

// File: rtl/doodle_plat_hit.sv
// Combinational landing test of the doodle box against one platform entry.
// Arithmetic is widened to 12 bits so plat_x + PLAT_W never overflows.
module doodle_plat_hit
    import doodle_pkg::*;
(
    input  logic              [9:0] x,
    input  logic              [9:0] y,
    input  logic signed       [9:0] vy_n,
    input  logic              [9:0] plat_x,
    input  logic              [9:0] plat_y,
    input  logic                    plat_valid,
    output logic                    hit
);

    logic [11:0] bottom;
    logic [11:0] bottom_next;
    logic [11:0] py;
    logic        falling;

    assign falling     = vy_n > 10'sd0;
    assign bottom      = {2'b00, y} + 12'(SIZE);
    // Only meaningful while falling, so vy_n is a plain magnitude here.
    assign bottom_next = bottom + {2'b00, vy_n};
    assign py          = {2'b00, plat_y};

    assign hit = plat_valid && falling
              && (bottom <= py) && (bottom_next >= py)
              && (({2'b00, x} + 12'(SIZE)) > {2'b00, plat_x})
              && ({2'b00, x} < ({2'b00, plat_x} + 12'(PLAT_W)));

endmodule

// File: rtl/doodle_jump_ctrl.sv
// Per-frame doodle physics: move, platform scan, commit with scroll/score, game over.
// Define DOODLE_WRAP_EN for horizontal wrap-around; default clamps X to the screen.
module doodle_jump_ctrl
    import doodle_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk,
    input  logic [7:0]       keycode,
    output logic [IDX_W-1:0] plat_idx,
    input  logic [9:0]       plat_x,
    input  logic [9:0]       plat_y,
    input  logic             plat_valid,
    output logic [9:0]       Doodle_X_out,
    output logic [9:0]       Doodle_Y_out,
    output logic [9:0]       scroll_dy,
    output logic             scroll_valid,
    output logic [15:0]      score,
    output logic             game_over
);

    localparam logic [9:0]         X_RST    = 10'((W - SIZE) / 2);
    localparam logic [9:0]         Y_RST    = 10'((H - SIZE) * 2 / 3);
    localparam logic signed [9:0]  VY_JUMP  = 10'(-JUMP_V);
    localparam logic signed [9:0]  VMAX_S   = 10'(VMAX);
    localparam logic signed [11:0] W_S      = 12'(W);
    localparam logic signed [11:0] H_S      = 12'(H);
    localparam logic signed [11:0] XMAX_S   = 12'(W - SIZE);
    localparam logic signed [11:0] SIZE_S   = 12'(SIZE);
    localparam logic signed [11:0] SCROLL_S = 12'(SCROLL_LINE);
    localparam logic [CNT_W-1:0]   CNT_END  = CNT_W'(N_PLAT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(N_PLAT - 1);

    ctrl_state_t state, state_n;

    logic              frame_clk_delayed;
    logic              frame_edge;
    logic [7:0]        key_r;
    logic signed [9:0] vy;
    logic signed [9:0] vy_n;
    logic signed [9:0] vy_inc;
    logic signed [9:0] vy_grav;
    logic [CNT_W-1:0]  scan_cnt;
    logic              landed;
    logic [9:0]        land_y;
    logic              hit;
    logic              scan_hit;
    logic signed [11:0] x_mv;
    logic signed [11:0] x_adj;
    logic signed [11:0] new_y;
    logic signed [11:0] scroll_amt;
    logic [16:0]       score_sum;
    logic              unused_bits;

    assign frame_edge = frame_clk & ~frame_clk_delayed;
    assign game_over  = (state == S_OVER);

    assign vy_inc  = vy + 10'(GRAV);
    assign vy_grav = (vy_inc > VMAX_S) ? VMAX_S : vy_inc;

    always_comb begin
        x_mv = $signed({2'b00, Doodle_X_out});
        if (key_r == KEY_A)
            x_mv = x_mv - 12'(X_STEP);
        else if (key_r == KEY_D)
            x_mv = x_mv + 12'(X_STEP);
        x_adj = x_mv;
`ifdef DOODLE_WRAP_EN
        if (x_mv < 12'sd0)
            x_adj = x_mv + W_S;
        else if (x_mv >= W_S)
            x_adj = x_mv - W_S;
`else
        if (x_mv < 12'sd0)
            x_adj = 12'sd0;
        else if (x_mv > XMAX_S)
            x_adj = XMAX_S;
`endif
    end

    // Entry scan_cnt-1 is on the plat_* inputs; scan_cnt==0 is the issue-only cycle.
    doodle_plat_hit u_hit (
        .x          (Doodle_X_out),
        .y          (Doodle_Y_out),
        .vy_n       (vy_n),
        .plat_x     (plat_x),
        .plat_y     (plat_y),
        .plat_valid (plat_valid),
        .hit        (hit)
    );

    assign scan_hit = (scan_cnt != '0) && hit;

    assign new_y = landed ? ($signed({2'b00, land_y}) - SIZE_S)
                          : ($signed({2'b00, Doodle_Y_out}) + {{2{vy_n[9]}}, vy_n});
    assign scroll_amt = SCROLL_S - new_y;
    assign score_sum  = {1'b0, score} + {7'b0, scroll_amt[9:0]};

    assign unused_bits = ^{x_adj[11:10], scroll_amt[11:10]};

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (frame_edge) state_n = S_MOVE;
            S_MOVE:   state_n = S_SCAN;
            S_SCAN:   if (scan_hit || scan_cnt == CNT_END) state_n = S_COMMIT;
            S_COMMIT: state_n = (new_y >= H_S) ? S_OVER : S_IDLE;
            S_OVER:   if (frame_edge && keycode == KEY_SPACE) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_delayed <= 1'b0;
            key_r             <= 8'h00;
            Doodle_X_out      <= X_RST;
            Doodle_Y_out      <= Y_RST;
            vy                <= VY_JUMP;
            vy_n              <= 10'sd0;
            scan_cnt          <= '0;
            plat_idx          <= '0;
            landed            <= 1'b0;
            land_y            <= 10'd0;
            scroll_dy         <= 10'd0;
            scroll_valid      <= 1'b0;
            score             <= 16'd0;
        end else begin
            frame_clk_delayed <= frame_clk;
            scroll_valid      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_edge)
                        key_r <= keycode;
                end
                S_MOVE: begin
                    Doodle_X_out <= x_adj[9:0];
                    vy_n         <= vy_grav;
                    landed       <= 1'b0;
                    scan_cnt     <= '0;
                    plat_idx     <= '0;
                end
                S_SCAN: begin
                    if (scan_hit) begin
                        landed <= 1'b1;
                        land_y <= plat_y;
                    end else if (scan_cnt != CNT_END) begin
                        scan_cnt <= scan_cnt + 1'b1;
                        if (scan_cnt < CNT_LAST)
                            plat_idx <= plat_idx + 1'b1;
                    end
                end
                S_COMMIT: begin
                    vy <= landed ? VY_JUMP : vy_n;
                    // Above the scroll line the world moves instead of the doodle.
                    if (new_y < SCROLL_S) begin
                        Doodle_Y_out <= 10'(SCROLL_LINE);
                        scroll_dy    <= scroll_amt[9:0];
                        scroll_valid <= 1'b1;
                        score        <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    end else begin
                        Doodle_Y_out <= new_y[9:0];
                    end
                end
                S_OVER: begin
                    if (frame_edge && keycode == KEY_SPACE) begin
                        Doodle_X_out <= X_RST;
                        Doodle_Y_out <= Y_RST;
                        vy           <= VY_JUMP;
                        score        <= 16'd0;
                        scroll_dy    <= 10'd0;
                        plat_idx     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_doodle_jump_ctrl.sv
// Randomized bench for doodle_jump_ctrl against a frame-level physics model.
// Honors DOODLE_WRAP_EN the same way the design does.
module tb_doodle_jump_ctrl;

    localparam int TW = 320, TH = 240, TS = 4, TPW = 16, TLINE = 80;
    localparam logic [7:0] K_A = 8'h04, K_D = 8'h07, K_SP = 8'h2C;

    logic       Clk = 0, Reset = 1, frame_clk = 0;
    logic [7:0] keycode = 0;
    logic [2:0] plat_idx;
    logic [9:0] plat_x = 0, plat_y = 0;
    logic       plat_valid = 0;
    logic [9:0] Doodle_X_out, Doodle_Y_out, scroll_dy;
    logic       scroll_valid, game_over;
    logic [15:0] score;

    int n_cmp = 0, n_err = 0;
    int pulse_cnt = 0, pulse_dy = 0;
    int mx, my, mvy, mscore, exp_pulses, exp_dy;
    bit mover;
    int tpx[8], tpy[8];
    bit tpv[8];

    doodle_jump_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
        .plat_idx(plat_idx), .plat_x(plat_x), .plat_y(plat_y), .plat_valid(plat_valid),
        .Doodle_X_out(Doodle_X_out), .Doodle_Y_out(Doodle_Y_out), .scroll_dy(scroll_dy),
        .scroll_valid(scroll_valid), .score(score), .game_over(game_over)
    );

    always #10 Clk = ~Clk;

    // Platform table RAM: one cycle read latency
    always @(posedge Clk) begin
        plat_x     <= 10'(tpx[plat_idx]);
        plat_y     <= 10'(tpy[plat_idx]);
        plat_valid <= tpv[plat_idx];
    end

    always @(negedge Clk) begin
        if (scroll_valid === 1'b1) begin
            pulse_cnt = pulse_cnt + 1;
            pulse_dy  = int'(scroll_dy);
        end
    end

    function automatic void model_reset();
        mx = (TW - TS) / 2; my = (TH - TS) * 2 / 3; mvy = -6; mscore = 0; mover = 0;
    endfunction

    function automatic int next_x(input logic [7:0] k);
        int nx;
        nx = mx + ((k == K_A) ? -3 : (k == K_D) ? 3 : 0);
`ifdef DOODLE_WRAP_EN
        if (nx < 0) nx += TW;
        else if (nx >= TW) nx -= TW;
`else
        if (nx < 0) nx = 0;
        if (nx > TW - TS) nx = TW - TS;
`endif
        return nx;
    endfunction

    function automatic void model_frame(input logic [7:0] k);
        int nx, vn, hit, ny;
        exp_pulses = 0;
        if (mover) begin
            if (k == K_SP) model_reset();
            return;
        end
        nx = next_x(k);
        vn = (mvy + 1 > 8) ? 8 : mvy + 1;
        hit = -1;
        for (int i = 0; i < 8; i++)
            if (hit < 0 && tpv[i] && vn > 0 && my + TS <= tpy[i] && my + TS + vn >= tpy[i]
                && nx + TS > tpx[i] && nx < tpx[i] + TPW)
                hit = i;
        mx = nx;
        if (hit >= 0) begin ny = tpy[hit] - TS; mvy = -6; end
        else begin ny = my + vn; mvy = vn; end
        if (ny < TLINE) begin
            exp_pulses = 1; exp_dy = TLINE - ny;
            mscore = (mscore + exp_dy > 65535) ? 65535 : mscore + exp_dy;
            ny = TLINE;
        end
        my = ny;
        if (ny >= TH) mover = 1;
    endfunction

    task automatic tbl_clear();
        for (int i = 0; i < 8; i++) begin tpv[i] = 0; tpx[i] = 0; tpy[i] = 0; end
    endtask

    task automatic tbl_under(input logic [7:0] k);
        int px;
        tbl_clear();
        px = next_x(k) - 6;
        tpx[0] = (px < 0) ? 0 : px;
        tpy[0] = my + TS;
        tpv[0] = 1;
    endtask

    task automatic tbl_random(input logic [7:0] k);
        int px;
        for (int i = 0; i < 8; i++) begin
            tpv[i] = ($urandom % 4) != 0;
            if ($urandom % 2) begin
                px = next_x(k) - 15 + int'($urandom_range(0, 20));
                tpx[i] = (px < 0) ? 0 : px;
                tpy[i] = my + TS + int'($urandom_range(0, 10));
            end else begin
                tpx[i] = int'($urandom_range(0, 319));
                tpy[i] = int'($urandom_range(0, 255));
            end
        end
    endtask

    task automatic do_frame(input logic [7:0] k);
        keycode = k; pulse_cnt = 0;
        frame_clk = 1;
        repeat (16) @(negedge Clk);
        frame_clk = 0;
        repeat (2) @(negedge Clk);
        model_frame(k);
    endtask

    task automatic test_reset();
        Reset = 1; frame_clk = 0; keycode = 0;
        repeat (3) @(negedge Clk);
        Reset = 0;
        model_reset();
        n_cmp += 7;
        if (Doodle_X_out !== 10'd158) begin n_err++; $display("FAIL reset_x got %0d want 158", Doodle_X_out); end
        if (Doodle_Y_out !== 10'd157) begin n_err++; $display("FAIL reset_y got %0d want 157", Doodle_Y_out); end
        if (score !== 16'd0) begin n_err++; $display("FAIL reset_score got %0d want 0", score); end
        if (game_over !== 1'b0) begin n_err++; $display("FAIL reset_over got %b want 0", game_over); end
        if (scroll_valid !== 1'b0) begin n_err++; $display("FAIL reset_sv got %b want 0", scroll_valid); end
        if (scroll_dy !== 10'd0) begin n_err++; $display("FAIL reset_dy got %0d want 0", scroll_dy); end
        if (plat_idx !== 3'd0) begin n_err++; $display("FAIL reset_idx got %0d want 0", plat_idx); end
    endtask

    task automatic test_first_frame();
        tbl_clear();
        do_frame(8'h00);
        n_cmp += 3;
        if (Doodle_X_out !== 10'(mx)) begin n_err++; $display("FAIL first_x got %0d want %0d", Doodle_X_out, mx); end
        if (Doodle_Y_out !== 10'(my)) begin n_err++; $display("FAIL first_y got %0d want %0d", Doodle_Y_out, my); end
        if (pulse_cnt !== 0) begin n_err++; $display("FAIL first_pulse got %0d want 0", pulse_cnt); end
    endtask

    task automatic test_move();
        logic [7:0] k;
        for (int f = 0; f < 90; f++) begin
            k = (f < 60) ? K_A : K_D;
            tbl_under(k);
            do_frame(k);
            n_cmp += 3;
            if (Doodle_X_out !== 10'(mx)) begin n_err++; $display("FAIL move_x f%0d got %0d want %0d", f, Doodle_X_out, mx); end
            if (Doodle_Y_out !== 10'(my)) begin n_err++; $display("FAIL move_y f%0d got %0d want %0d", f, Doodle_Y_out, my); end
            if (game_over !== mover) begin n_err++; $display("FAIL move_over f%0d got %b want %b", f, game_over, mover); end
        end
    endtask

    task automatic test_climb();
        for (int f = 0; f < 100; f++) begin
            tbl_under(8'h00);
            do_frame(8'h00);
            n_cmp += 4;
            if (Doodle_Y_out !== 10'(my)) begin n_err++; $display("FAIL climb_y f%0d got %0d want %0d", f, Doodle_Y_out, my); end
            if (score !== 16'(mscore)) begin n_err++; $display("FAIL climb_score f%0d got %0d want %0d", f, score, mscore); end
            if (pulse_cnt !== exp_pulses) begin n_err++; $display("FAIL climb_pulses f%0d got %0d want %0d", f, pulse_cnt, exp_pulses); end
            if (exp_pulses == 1 && pulse_dy !== exp_dy) begin n_err++; $display("FAIL climb_dy f%0d got %0d want %0d", f, pulse_dy, exp_dy); end
        end
    endtask

    task automatic test_game_over();
        tbl_clear();
        for (int f = 0; f < 40 && !mover; f++) begin
            do_frame(8'h00);
            n_cmp += 2;
            if (Doodle_Y_out !== 10'(my)) begin n_err++; $display("FAIL fall_y f%0d got %0d want %0d", f, Doodle_Y_out, my); end
            if (game_over !== mover) begin n_err++; $display("FAIL fall_over f%0d got %b want %b", f, game_over, mover); end
        end
        n_cmp++;
        if (game_over !== 1'b1) begin n_err++; $display("FAIL over_reached got %b want 1", game_over); end
        for (int f = 0; f < 2; f++) begin
            do_frame(K_D);
            n_cmp += 3;
            if (Doodle_X_out !== 10'(mx)) begin n_err++; $display("FAIL frozen_x got %0d want %0d", Doodle_X_out, mx); end
            if (Doodle_Y_out !== 10'(my)) begin n_err++; $display("FAIL frozen_y got %0d want %0d", Doodle_Y_out, my); end
            if (game_over !== 1'b1) begin n_err++; $display("FAIL frozen_over got %b want 1", game_over); end
        end
        do_frame(K_SP);
        n_cmp += 5;
        if (game_over !== 1'b0) begin n_err++; $display("FAIL restart_over got %b want 0", game_over); end
        if (Doodle_X_out !== 10'd158) begin n_err++; $display("FAIL restart_x got %0d want 158", Doodle_X_out); end
        if (Doodle_Y_out !== 10'd157) begin n_err++; $display("FAIL restart_y got %0d want 157", Doodle_Y_out); end
        if (score !== 16'd0) begin n_err++; $display("FAIL restart_score got %0d want 0", score); end
        if (scroll_dy !== 10'd0) begin n_err++; $display("FAIL restart_dy got %0d want 0", scroll_dy); end
    endtask

    task automatic test_scan_edge();
        tbl_clear();
        keycode = K_D; pulse_cnt = 0;
        frame_clk = 1;
        repeat (4) @(negedge Clk);
        frame_clk = 0;
        @(negedge Clk);
        frame_clk = 1;
        repeat (14) @(negedge Clk);
        frame_clk = 0;
        repeat (2) @(negedge Clk);
        model_frame(K_D);
        n_cmp += 2;
        if (Doodle_X_out !== 10'(mx)) begin n_err++; $display("FAIL scan_edge_x got %0d want %0d", Doodle_X_out, mx); end
        if (Doodle_Y_out !== 10'(my)) begin n_err++; $display("FAIL scan_edge_y got %0d want %0d", Doodle_Y_out, my); end
    endtask

    task automatic test_reset_mid_scan();
        tbl_clear();
        keycode = K_A;
        frame_clk = 1;
        repeat (5) @(negedge Clk);
        Reset = 1; frame_clk = 0;
        @(negedge Clk);
        n_cmp += 4;
        if (Doodle_X_out !== 10'd158) begin n_err++; $display("FAIL midrst_x got %0d want 158", Doodle_X_out); end
        if (Doodle_Y_out !== 10'd157) begin n_err++; $display("FAIL midrst_y got %0d want 157", Doodle_Y_out); end
        if (plat_idx !== 3'd0) begin n_err++; $display("FAIL midrst_idx got %0d want 0", plat_idx); end
        if (score !== 16'd0) begin n_err++; $display("FAIL midrst_score got %0d want 0", score); end
        Reset = 0;
        model_reset();
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_random();
        logic [7:0] k;
        int r;
        for (int f = 0; f < 150; f++) begin
            r = int'($urandom_range(0, 9));
            k = (r < 3) ? K_A : (r < 6) ? K_D : (r < 8) ? 8'h00 : 8'($urandom);
            if (mover && ($urandom % 2)) k = K_SP;
            if (k == K_SP && !mover) k = 8'h00;
            tbl_random(k);
            do_frame(k);
            n_cmp += 5;
            if (Doodle_X_out !== 10'(mx)) begin n_err++; $display("FAIL rand_x f%0d got %0d want %0d", f, Doodle_X_out, mx); end
            if (Doodle_Y_out !== 10'(my)) begin n_err++; $display("FAIL rand_y f%0d got %0d want %0d", f, Doodle_Y_out, my); end
            if (score !== 16'(mscore)) begin n_err++; $display("FAIL rand_score f%0d got %0d want %0d", f, score, mscore); end
            if (game_over !== mover) begin n_err++; $display("FAIL rand_over f%0d got %b want %b", f, game_over, mover); end
            if (pulse_cnt !== exp_pulses) begin n_err++; $display("FAIL rand_pulses f%0d got %0d want %0d", f, pulse_cnt, exp_pulses); end
        end
    endtask

    initial begin
        tbl_clear();
        test_reset();
        test_first_frame();
        test_move();
        test_climb();
        test_game_over();
        test_scan_edge();
        test_reset_mid_scan();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
